dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4, is the number of consecutive cycles a debug request may be refused before it is force-granted (legal range 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 c_req, c_we  input  1 each  core (MEM-stage) access request and write-enable (1=store, 0=load).
REQ-005 c_addr, c_wdata  input  32 each  core address and store data.
REQ-006 c_gnt  output  1  core access granted this cycle.
REQ-007 c_stall  output  1  core must hold its pipeline (c_req and not c_gnt).
REQ-008 c_rvalid / c_rdata  output  1 / 32  core load data valid / value.
REQ-009 d_req, d_we  input  1 each  debug/loader request and write-enable.
REQ-010 d_addr, d_wdata  input  32 each  debug address and write data.
REQ-011 d_gnt, d_rvalid  output  1 each  debug grant and load-data valid.
REQ-012 d_rdata  output  32  debug load data.
REQ-013 m_addr, m_wdata  output  32 each  shared DMEM address and write data.
REQ-014 m_memr, m_memw  output  1 each  shared DMEM read and write strobes.
REQ-015 m_rdata  input  32  DMEM read data, combinational from m_addr within the same cycle.

Function
REQ-016 Requests are level-sensitive: requester holds req, we, addr and wdata stable until it samples its gnt high at a rising edge.
REQ-017 Grants are combinational from current req inputs and registered arbitration state; at most one of c_gnt and d_gnt is 1 in any cycle.
REQ-018 Arbitration state: 4-bit wait counter wcnt plus FSM with states NORMAL and FORCE.
REQ-019 NORMAL: c_req=1 grants core; otherwise d_req=1 grants debug; neither -> no grant.
REQ-020 NORMAL: each cycle d_req=1 and d_gnt=0 increments wcnt; any d_gnt=1 or d_req=0 clears wcnt to 0.
REQ-021 NORMAL -> FORCE at the edge where wcnt would reach MAX_WAIT; wcnt saturates there, never wraps.
REQ-022 FORCE: d_req=1 grants debug regardless of c_req; next state NORMAL, wcnt cleared.
REQ-023 FORCE with d_req=0 (request withdrawn): behaves as NORMAL for that cycle, next state NORMAL, wcnt cleared.
REQ-024 In a grant cycle m_addr/m_wdata carry the winner's addr/wdata, m_memw=we, m_memr=not we; with no grant m_addr=0, m_wdata=0, m_memr=0, m_memw=0.
REQ-025 Store commits to DMEM at the rising edge ending the grant cycle; no response is generated for stores.
REQ-026 Load: m_rdata is registered at the end of the grant cycle; the granted port's rvalid=1 for exactly the next cycle with rdata equal to that value (latency 1).
REQ-027 rdata of each port holds its last load value while rvalid=0; the non-granted port's rvalid stays 0.
REQ-028 Back-to-back grants allowed every cycle; a new grant may coincide with the previous load's rvalid.
REQ-029 Accesses from both ports to the same address are ordered strictly by grant order; read-after-write across ports sees the written value.
REQ-030 c_stall = c_req and not c_gnt, combinational.

Reset
REQ-031 While reset=0: FSM=NORMAL, wcnt=0, c_gnt=d_gnt=0, c_rvalid=d_rvalid=0, c_rdata=d_rdata=0, m_memr=m_memw=0, m_addr=m_wdata=0, c_stall=0.
REQ-032 Reset asserted mid-load discards the pending response; no rvalid pulses after reset release until a new grant.
REQ-033 First grant is possible in the first cycle after reset deasserts.

Verification
REQ-034 Core alone: c_req=1, c_we=0, c_addr=0x10, DMEM[0x10]=0xA5A5A5A5 -> c_gnt=1 same cycle, c_rvalid=1 and c_rdata=0xA5A5A5A5 next cycle.
REQ-035 Simultaneous c_req=d_req=1 held, MAX_WAIT=4 -> core granted 4 consecutive cycles, debug granted on 5th, core on 6th; c_stall=1 only in cycle 5.
REQ-036 Debug store d_addr=0x20, d_wdata=0x1234 granted, core load 0x20 next cycle -> c_rdata=0x1234.
REQ-037 d_req dropped while FSM=FORCE with c_req=1 -> core granted, wcnt=0, state NORMAL next cycle.
REQ-038 reset=0 asserted in the grant cycle of a debug load -> d_rvalid stays 0 after release, all outputs at reset values.
REQ-039 Idle (no requests) -> m_memr=m_memw=0, m_addr=0, both gnt=0, wcnt stays 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port (core / debug) arbiter in front of a single-port DMEM with combinational read data.
// Core has priority; debug is force-granted after MAX_WAIT consecutive refusals; load data returns one cycle later.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_stall,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_memr,
  output logic        m_memw,
  input  logic [31:0] m_rdata
);

  typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wcnt, wcnt_nxt;
  logic        c_win, d_win;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= NORMAL;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Any cycle that is not a refused debug request in NORMAL returns to NORMAL with a clear count.
  always_comb begin
    state_nxt = NORMAL;
    wcnt_nxt  = '0;
    if (state == NORMAL && d_req && !d_win) begin
      if (wcnt + 4'd1 >= 4'(MAX_WAIT)) begin
        state_nxt = FORCE;
        wcnt_nxt  = 4'(MAX_WAIT);
      end else begin
        wcnt_nxt  = wcnt + 4'd1;
      end
    end
  end

  // Grants are suppressed while reset is held so no strobe reaches DMEM during reset.
  always_comb begin
    c_win   = reset && c_req && !(state == FORCE && d_req);
    d_win   = reset && d_req && (state == FORCE || !c_req);
    c_gnt   = c_win;
    d_gnt   = d_win;
    c_stall = reset && c_req && !c_win;
    m_addr  = '0;
    m_wdata = '0;
    m_memr  = 1'b0;
    m_memw  = 1'b0;
    if (c_win) begin
      m_addr  = c_addr;
      m_wdata = c_wdata;
      m_memr  = !c_we;
      m_memw  = c_we;
    end else if (d_win) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_memr  = !d_we;
      m_memw  = d_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= c_win && !c_we;
      d_rvalid <= d_win && !d_we;
      if (c_win && !c_we) c_rdata <= m_rdata;
      if (d_win && !d_we) d_rdata <= m_rdata;
    end
  end

endmodule
